// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the decode stage.
//
// Owns the program counter and issues one instruction-memory request at a time
// over a variable-latency req/ack handshake. Fetched words are registered into
// pc_o/inst_o for decode. Honours the pipeline stall: a word acked while
// stalled is parked in a one-entry hold buffer. Handles MIPS-style branches
// with a single delay slot. The delay-slot word is always delivered before the
// target stream.
//
// Ports:
//   clk                      clock, all state updates on the rising edge
//   rst                      synchronous active-low reset
//   stall_i                  decode holds its current instruction
//   branch_flag_i            decode resolved a taken branch this cycle
//   branch_target_address_i  branch target, valid with branch_flag_i
//   imem_req_o               fetch request, held until imem_ack_i
//   imem_addr_o              fetch address, stable while imem_req_o is high
//   imem_ack_i               memory completes the request this cycle
//   imem_rdata_i             instruction word, valid with imem_ack_i
//   pc_o                     address of the instruction presented to decode
//   inst_o                   instruction presented to decode (0 when invalid)
//   inst_valid_o             pc_o/inst_o hold a real instruction
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_inst_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;

  // Request and address come straight from registers, so a request is never
  // withdrawn or re-addressed until the FSM leaves StFetch on an ack.
  assign imem_req_o  = (state_q == StFetch);
  assign imem_addr_o = pc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_pc_q    <= 32'h0;
      hold_inst_q  <= 32'h0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      inst_valid_o <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end

        StFetch: begin
          if (imem_ack_i) begin
            if (!stall_i) begin
              pc_o         <= pc_q;
              inst_o       <= imem_rdata_i;
              inst_valid_o <= 1'b1;
            end else begin
              hold_pc_q   <= pc_q;
              hold_inst_q <= imem_rdata_i;
              state_q     <= StHold;
            end
            // A branch seen now makes the captured word the delay slot, so
            // the next fetch goes straight to the target.
            if (!stall_i && branch_flag_i) begin
              pc_q         <= branch_target_address_i;
              redir_pend_q <= 1'b0;
            end else if (redir_pend_q) begin
              pc_q         <= redir_tgt_q;
              redir_pend_q <= 1'b0;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end else if (!stall_i) begin
            pc_o         <= 32'h0;
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
            // The outstanding request is the delay slot; redirect at its ack.
            if (branch_flag_i) begin
              redir_pend_q <= 1'b1;
              redir_tgt_q  <= branch_target_address_i;
            end
          end
        end

        StHold: begin
          if (!stall_i) begin
            pc_o         <= hold_pc_q;
            inst_o       <= hold_inst_q;
            inst_valid_o <= 1'b1;
            state_q      <= StFetch;
            // Buffered word is the delay slot and nothing is outstanding.
            if (branch_flag_i) begin
              pc_q <= branch_target_address_i;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural instruction memory that
// returns addr + 0x100 after a programmable number of wait cycles.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int vectors;
  int miscompares;
  int waits;
  int wait_cnt;

  if_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_i                (stall_i),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .imem_req_o             (imem_req_o),
    .imem_addr_o            (imem_addr_o),
    .imem_ack_i             (imem_ack_i),
    .imem_rdata_i           (imem_rdata_i),
    .pc_o                   (pc_o),
    .inst_o                 (inst_o),
    .inst_valid_o           (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after 'waits' cycles of a held request.
  always_comb begin
    imem_ack_i   = imem_req_o && (wait_cnt == waits);
    imem_rdata_i = imem_addr_o + 32'h100;
  end

  always @(posedge clk) begin
    if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic valid);
    chk({tag, ".pc_o"}, pc_o, pc);
    chk({tag, ".inst_o"}, inst_o, inst);
    chk({tag, ".valid"}, {31'h0, inst_valid_o}, {31'h0, valid});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, req});
    if (req) chk({tag, ".addr"}, imem_addr_o, addr);
  endtask

  // Two reset edges, then release; the next edge leaves IDLE.
  task automatic do_reset(input int w);
    rst           = 1'b0;
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    waits         = w;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    vectors                 = 0;
    miscompares             = 0;
    wait_cnt                = 0;
    branch_target_address_i = 32'h0;

    // Reset and zero-wait startup.
    do_reset(0);
    chk_out("rst", 32'h0, 32'h0, 1'b0);
    chk_req("rst", 1'b0, 32'h0);
    tick();
    chk_req("start", 1'b1, 32'h0);
    chk_out("start", 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("zw", 32'(4 * k), 32'(32'h100 + 4 * k), 1'b1);
      chk_req("zw", 1'b1, 32'(4 * k + 4));
    end

    // Two-wait memory: address held 3 cycles, two bubbles per instruction.
    do_reset(2);
    tick();
    chk_req("w2.first", 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_req("w2.b1", 1'b1, 32'(4 * k));
      chk_out("w2.b1", 32'h0, 32'h0, 1'b0);
      tick();
      chk_req("w2.b2", 1'b1, 32'(4 * k));
      chk_out("w2.b2", 32'h0, 32'h0, 1'b0);
      tick();
      chk_out("w2.out", 32'(4 * k), 32'(32'h100 + 4 * k), 1'b1);
      chk_req("w2.next", 1'b1, 32'(4 * k + 4));
    end

    // Stall for 3 cycles while an ack arrives.
    do_reset(0);
    tick();
    tick();
    chk_out("st.pre", 32'h0, 32'h100, 1'b1);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_req("st.hold", 1'b0, 32'h0);
      chk_out("st.hold", 32'h0, 32'h100, 1'b1);
    end
    stall_i = 1'b0;
    tick();
    chk_out("st.rel", 32'h4, 32'h104, 1'b1);
    chk_req("st.rel", 1'b1, 32'h8);
    tick();
    chk_out("st.next", 32'h8, 32'h108, 1'b1);

    // Branch at 0x20 to 0x80, zero-wait.
    do_reset(0);
    tick();
    for (int k = 0; k < 9; k++) tick();
    chk_out("bz.br", 32'h20, 32'h120, 1'b1);
    branch_flag_i           = 1'b1;
    branch_target_address_i = 32'h80;
    tick();
    branch_flag_i = 1'b0;
    chk_out("bz.ds", 32'h24, 32'h124, 1'b1);
    chk_req("bz.ds", 1'b1, 32'h80);
    tick();
    chk_out("bz.t0", 32'h80, 32'h180, 1'b1);
    tick();
    chk_out("bz.t1", 32'h84, 32'h184, 1'b1);

    // Same branch with two-wait memory; redirect pends until the 0x24 ack.
    do_reset(2);
    tick();
    for (int k = 0; k < 27; k++) tick();
    chk_out("bw.br", 32'h20, 32'h120, 1'b1);
    chk_req("bw.br", 1'b1, 32'h24);
    branch_flag_i           = 1'b1;
    branch_target_address_i = 32'h80;
    tick();
    branch_flag_i = 1'b0;
    chk_out("bw.b1", 32'h0, 32'h0, 1'b0);
    chk_req("bw.b1", 1'b1, 32'h24);
    tick();
    chk_req("bw.b2", 1'b1, 32'h24);
    tick();
    chk_out("bw.ds", 32'h24, 32'h124, 1'b1);
    chk_req("bw.ds", 1'b1, 32'h80);
    tick();
    tick();
    tick();
    chk_out("bw.t0", 32'h80, 32'h180, 1'b1);
    tick();
    tick();
    tick();
    chk_out("bw.t1", 32'h84, 32'h184, 1'b1);

    // Branch on HOLD release, then PC wrap past 32'hFFFF_FFFC.
    do_reset(0);
    tick();
    tick();
    stall_i = 1'b1;
    tick();
    chk_req("hb.hold", 1'b0, 32'h0);
    stall_i                 = 1'b0;
    branch_flag_i           = 1'b1;
    branch_target_address_i = 32'hFFFF_FFF8;
    tick();
    branch_flag_i = 1'b0;
    chk_out("hb.ds", 32'h4, 32'h104, 1'b1);
    chk_req("hb.ds", 1'b1, 32'hFFFF_FFF8);
    tick();
    chk_out("hb.t0", 32'hFFFF_FFF8, 32'h0000_00F8, 1'b1);
    chk_req("hb.t0", 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_out("wrap.fc", 32'hFFFF_FFFC, 32'h0000_00FC, 1'b1);
    chk_req("wrap.fc", 1'b1, 32'h0);
    tick();
    chk_out("wrap.0", 32'h0, 32'h100, 1'b1);

    // Reset with a request outstanding and its ack landing in the reset cycle.
    do_reset(2);
    tick();
    tick();
    tick();
    tick();
    chk_out("mr.pre", 32'h0, 32'h100, 1'b1);
    tick();
    tick();
    chk_req("mr.pend", 1'b1, 32'h4);
    rst = 1'b0;
    tick();
    chk_req("mr.rst", 1'b0, 32'h0);
    chk_out("mr.rst", 32'h0, 32'h0, 1'b0);
    chk("mr.addr", imem_addr_o, 32'h0);
    rst = 1'b1;
    tick();
    chk_req("mr.restart", 1'b1, 32'h0);
    tick();
    tick();
    tick();
    chk_out("mr.first", 32'h0, 32'h100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
